// File: rtl/decoder_3to8_if.sv
// Select/enable inputs and one-hot Y outputs of the 3-to-8 decoder.
// The master drives the select bus; the slave (the decoder) returns the strobes.
interface decoder_3to8_if;
  logic A;
  logic B;
  logic C;
  logic en;
  logic Y7;
  logic Y6;
  logic Y5;
  logic Y4;
  logic Y3;
  logic Y2;
  logic Y1;
  logic Y0;

  modport master (
    output A, B, C, en,
    input  Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0
  );

  modport slave (
    input  A, B, C, en,
    output Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0
  );
endinterface

// File: rtl/decoder_3to8.sv
// Clocked 3-to-8 one-hot decoder with enable, used as a chip-select strobe generator.
// Optional output register (glitch-free strobes) and optional active-low polarity.
module decoder_3to8 #(
  parameter bit REGISTERED = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_3to8_if.slave        bus
);

  logic [2:0] w_sel;
  logic [7:0] w_dec;
  logic [7:0] w_yActiveHigh;
  logic [7:0] w_y;

  assign w_sel = {bus.A, bus.B, bus.C};

  // Unknown select bits fall through to the default, so no line is ever
  // asserted on an undefined code.
  always_comb begin
    w_dec = 8'h00;
    if (bus.en) begin
      case (w_sel)
        3'b000:  w_dec = 8'b0000_0001;
        3'b001:  w_dec = 8'b0000_0010;
        3'b010:  w_dec = 8'b0000_0100;
        3'b011:  w_dec = 8'b0000_1000;
        3'b100:  w_dec = 8'b0001_0000;
        3'b101:  w_dec = 8'b0010_0000;
        3'b110:  w_dec = 8'b0100_0000;
        3'b111:  w_dec = 8'b1000_0000;
        default: w_dec = 8'h00;
      endcase
    end
  end

  generate
    if (REGISTERED) begin : g_registered
      logic [7:0] r_y;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_y <= 8'h00;
        end else begin
          r_y <= w_dec;
        end
      end

      assign w_yActiveHigh = r_y;
    end else begin : g_combinational
      assign w_yActiveHigh = w_dec;
    end
  endgenerate

  // Polarity is applied after the register so reset and disabled values invert too.
  assign w_y = ACTIVE_LOW ? ~w_yActiveHigh : w_yActiveHigh;

  assign bus.Y7 = w_y[7];
  assign bus.Y6 = w_y[6];
  assign bus.Y5 = w_y[5];
  assign bus.Y4 = w_y[4];
  assign bus.Y3 = w_y[3];
  assign bus.Y2 = w_y[2];
  assign bus.Y1 = w_y[1];
  assign bus.Y0 = w_y[0];

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed self-checking bench for decoder_3to8 in its default configuration
// (registered, active-high outputs).
module tb_decoder_3to8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  decoder_3to8_if bus ();

  decoder_3to8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] yObs;
  assign yObs = {bus.Y7, bus.Y6, bus.Y5, bus.Y4, bus.Y3, bus.Y2, bus.Y1, bus.Y0};

  always #5 clk = ~clk;

  task automatic drive(input logic e, input logic [2:0] s);
    bus.en = e;
    {bus.A, bus.B, bus.C} = s;
  endtask

  task automatic test_reset();
    drive(1'b1, 3'b011);
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (yObs !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: got %b, expected %b", yObs, 8'h00);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      testsRun++;
      if (yObs !== 8'h00) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold: got %b, expected %b", yObs, 8'h00);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    testsRun++;
    if (yObs !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_no_edge: got %b, expected %b", yObs, 8'h00);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'b0000_1000) begin
      testsFailed++;
      $display("[TB] FAIL first_decode: got %b, expected %b", yObs, 8'b0000_1000);
    end
  endtask

  task automatic test_disabled();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b0, i[2:0]);
      @(posedge clk);
      #1;
      testsRun++;
      if (yObs !== 8'h00) begin
        testsFailed++;
        $display("[TB] FAIL disabled_sel%0d: got %b, expected %b", i, yObs, 8'h00);
      end
    end
  endtask

  task automatic test_decode();
    logic [2:0] selTab [4];
    logic [7:0] expTab [4];
    selTab = '{3'b000, 3'b010, 3'b100, 3'b110};
    expTab = '{8'b0000_0001, 8'b0000_0100, 8'b0001_0000, 8'b0100_0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, selTab[i]);
      @(posedge clk);
      #1;
      testsRun++;
      if (yObs !== expTab[i]) begin
        testsFailed++;
        $display("[TB] FAIL decode_sel%b: got %b, expected %b", selTab[i], yObs, expTab[i]);
      end
    end
  endtask

  task automatic test_en_drop();
    @(negedge clk);
    drive(1'b1, 3'b110);
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'b0100_0000) begin
      testsFailed++;
      $display("[TB] FAIL en_high_110: got %b, expected %b", yObs, 8'b0100_0000);
    end
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL en_drop: got %b, expected %b", yObs, 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 3'b111);
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'b1000_0000) begin
      testsFailed++;
      $display("[TB] FAIL mid_pre: got %b, expected %b", yObs, 8'b1000_0000);
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (yObs !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL mid_async_drop: got %b, expected %b", yObs, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    testsRun++;
    if (yObs !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL mid_no_stale: got %b, expected %b", yObs, 8'h00);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'b1000_0000) begin
      testsFailed++;
      $display("[TB] FAIL mid_redecode: got %b, expected %b", yObs, 8'b1000_0000);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 3'b011);
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'b0000_1000) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: got %b, expected %b", yObs, 8'b0000_1000);
    end
    @(negedge clk);
    drive(1'b0, 3'b101);
    #1;
    testsRun++;
    if (yObs !== 8'b0000_1000) begin
      testsFailed++;
      $display("[TB] FAIL hold_between_edges: got %b, expected %b", yObs, 8'b0000_1000);
    end
    #1 drive(1'b1, 3'b110);
    #1 drive(1'b0, 3'b101);
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL glitch_invisible: got %b, expected %b", yObs, 8'h00);
    end
    @(negedge clk);
    drive(1'b1, 3'b101);
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'b0010_0000) begin
      testsFailed++;
      $display("[TB] FAIL en_rise_101: got %b, expected %b", yObs, 8'b0010_0000);
    end
    @(negedge clk);
    drive(1'b1, 3'b001);
    @(posedge clk);
    #1;
    testsRun++;
    if (yObs !== 8'b0000_0010) begin
      testsFailed++;
      $display("[TB] FAIL b2b_001: got %b, expected %b", yObs, 8'b0000_0010);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] v;
    logic [7:0] expY;
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      @(negedge clk);
      drive(v[3], v[2:0]);
      @(posedge clk);
      #1;
      expY = v[3] ? (8'b0000_0001 << v[2:0]) : 8'h00;
      testsRun++;
      if ($countones(yObs) > 1) begin
        testsFailed++;
        $display("[TB] FAIL onehot_%b: got %b, expected at most one bit set", v, yObs);
      end
      testsRun++;
      if (yObs !== expY) begin
        testsFailed++;
        $display("[TB] FAIL sweep_%b: got %b, expected %b", v, yObs, expY);
      end
    end
  endtask

  initial begin
    drive(1'b0, 3'b000);
    test_reset();
    test_disabled();
    test_decode();
    test_en_drop();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
